// File: rtl/spdif_channel_status_sequencer.sv
// spdif_channel_status_sequencer
//   Builds the 192-bit IEC 60958-3 consumer Channel Status word for each of
//   NUM_CHANNELS channels and serialises it one bit per IEC frame, aligned to
//   block start. The configuration is latched into a shadow copy at each block
//   boundary, so a block is never torn by a mid-block input change.
//   Optional feature macro: SPDIF_CS_CRCC_EN (per-channel CRC-8 in cs[191:184]).
// Ports
//   clk            system clock, rising edge
//   nReset         synchronous active-low reset
//   enable         run request, sampled only at block boundaries
//   frameStrobe    one-cycle pulse per IEC frame
//   categoryCode   cs[15:8]
//   samplingFreq   cs[27:24], inverted copy in cs[39:36]
//   wordLength     cs[35:32]
//   copyPermit     cs[2]
//   preEmphasis    cs[5:3] = 001 when set
//   channelNumEn   cs[23:20] = channel+1 when set, else 0
//   csBits         current cs bit, one per channel
//   blockStart     high while csBits carries cs bit 0
//   frameIndex     index 0..191 of the bit on csBits
//   configLatched  one-cycle pulse when the shadow config is loaded
module spdif_channel_status_sequencer #(
  parameter int unsigned NUM_CHANNELS   = 2,
  parameter logic [1:0]  CLOCK_ACCURACY = 2'b00
) (
  input  logic                    clk,
  input  logic                    nReset,
  input  logic                    enable,
  input  logic                    frameStrobe,
  input  logic [7:0]              categoryCode,
  input  logic [3:0]              samplingFreq,
  input  logic [3:0]              wordLength,
  input  logic                    copyPermit,
  input  logic                    preEmphasis,
  input  logic                    channelNumEn,
  output logic [NUM_CHANNELS-1:0] csBits,
  output logic                    blockStart,
  output logic [7:0]              frameIndex,
  output logic                    configLatched
);

  typedef enum logic {IDLE, RUN} state_t;
  state_t state;

  logic [7:0] sh_cat;
  logic [3:0] sh_fs, sh_wl;
  logic       sh_copy, sh_pre, sh_chen;

  logic       wrap, load, stop, advance;
  logic [7:0] nidx;
  logic [7:0] cf_cat;
  logic [3:0] cf_fs, cf_wl;
  logic       cf_copy, cf_pre, cf_chen;

  logic [39:0]             words [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] next_bits;

`ifdef SPDIF_CS_CRCC_EN
  logic [7:0] crc_q    [NUM_CHANNELS];
  logic [7:0] crc_next [NUM_CHANNELS];
  logic [7:0] crc_seed;
`endif

  function automatic logic [39:0] cs_word(
    input logic [7:0] cat,
    input logic [3:0] fs,
    input logic [3:0] wl,
    input logic       copy,
    input logic       pre,
    input logic [3:0] chnum
  );
    return {~fs, wl, 2'b00, CLOCK_ACCURACY, fs, chnum, 4'b0000,
            cat, 2'b00, (pre ? 3'b001 : 3'b000), copy, 2'b00};
  endfunction

  // The bit emitted at a block boundary must come from the config being
  // loaded on that same edge, so bit selection looks through the shadow.
  always_comb begin
    wrap    = (state == RUN) && (frameIndex == 8'd191);
    load    = enable && ((state == IDLE) || wrap);
    stop    = wrap && !enable;
    advance = (state == RUN) || enable;
    nidx    = ((state == IDLE) || wrap) ? 8'd0 : frameIndex + 8'd1;
    cf_cat  = load ? categoryCode : sh_cat;
    cf_fs   = load ? samplingFreq : sh_fs;
    cf_wl   = load ? wordLength   : sh_wl;
    cf_copy = load ? copyPermit   : sh_copy;
    cf_pre  = load ? preEmphasis  : sh_pre;
    cf_chen = load ? channelNumEn : sh_chen;
  end

  always_comb begin
    words = '{default: '0};
    for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
      words[c] = cs_word(cf_cat, cf_fs, cf_wl, cf_copy, cf_pre,
                         cf_chen ? 4'(c + 1) : 4'd0);
    end
  end

  always_comb begin
    next_bits = '0;
`ifdef SPDIF_CS_CRCC_EN
    crc_next = '{default: '0};
    crc_seed = '0;
`endif
    for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
      if (nidx < 8'd40) next_bits[c] = words[c][nidx[5:0]];
`ifdef SPDIF_CS_CRCC_EN
      // 184..191 share low bits 0..7, so nidx[2:0] selects the CRC bit.
      if (nidx >= 8'd184) next_bits[c] = crc_q[c][nidx[2:0]];
      crc_seed    = (nidx == 8'd0) ? 8'hFF : crc_q[c];
      crc_next[c] = {crc_seed[6:0], 1'b0} ^
                    ((crc_seed[7] ^ next_bits[c]) ? 8'h1D : 8'h00);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!nReset) begin
      state         <= IDLE;
      csBits        <= '0;
      blockStart    <= 1'b0;
      frameIndex    <= '0;
      configLatched <= 1'b0;
      sh_cat        <= '0;
      sh_fs         <= '0;
      sh_wl         <= '0;
      sh_copy       <= 1'b0;
      sh_pre        <= 1'b0;
      sh_chen       <= 1'b0;
`ifdef SPDIF_CS_CRCC_EN
      for (int unsigned c = 0; c < NUM_CHANNELS; c++) crc_q[c] <= '0;
`endif
    end else begin
      configLatched <= 1'b0;
      if (frameStrobe) begin
        if (load) begin
          sh_cat        <= categoryCode;
          sh_fs         <= samplingFreq;
          sh_wl         <= wordLength;
          sh_copy       <= copyPermit;
          sh_pre        <= preEmphasis;
          sh_chen       <= channelNumEn;
          configLatched <= 1'b1;
        end
        if (stop) begin
          state      <= IDLE;
          csBits     <= '0;
          frameIndex <= '0;
          blockStart <= 1'b0;
        end else if (advance) begin
          state      <= RUN;
          csBits     <= next_bits;
          frameIndex <= nidx;
          blockStart <= (nidx == 8'd0);
`ifdef SPDIF_CS_CRCC_EN
          for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
            if (nidx < 8'd184) crc_q[c] <= crc_next[c];
          end
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_spdif_channel_status_sequencer.sv
module tb_spdif_channel_status_sequencer;

  localparam int unsigned NC = 2;

  logic          clk = 1'b0;
  logic          nReset, enable, frameStrobe;
  logic [7:0]    categoryCode;
  logic [3:0]    samplingFreq, wordLength;
  logic          copyPermit, preEmphasis, channelNumEn;
  logic [NC-1:0] csBits;
  logic          blockStart;
  logic [7:0]    frameIndex;
  logic          configLatched;

  spdif_channel_status_sequencer #(
    .NUM_CHANNELS  (NC),
    .CLOCK_ACCURACY(2'b00)
  ) dut (
    .clk          (clk),
    .nReset       (nReset),
    .enable       (enable),
    .frameStrobe  (frameStrobe),
    .categoryCode (categoryCode),
    .samplingFreq (samplingFreq),
    .wordLength   (wordLength),
    .copyPermit   (copyPermit),
    .preEmphasis  (preEmphasis),
    .channelNumEn (channelNumEn),
    .csBits       (csBits),
    .blockStart   (blockStart),
    .frameIndex   (frameIndex),
    .configLatched(configLatched)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] cat;
    logic [3:0] fs;
    logic [3:0] wl;
    logic       copy;
    logic       pre;
    logic       chen;
  } cfg_t;

  typedef struct packed {
    logic [NC-1:0] bits;
    logic          bs;
    logic [7:0]    idx;
    logic          cl;
  } exp_t;

  exp_t q[$];

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // reference model state
  logic          m_run;
  logic [7:0]    m_idx;
  logic [191:0]  m_word [NC];
  logic [NC-1:0] m_bits;
  logic          m_bs;
  logic [7:0]    m_oidx;
  logic          m_cl;

  logic [191:0]  cap [NC];
  logic [191:0]  capA, capB;

  function automatic logic [191:0] build_word(input cfg_t cfg, input int unsigned ch);
    logic [191:0] w;
    logic [7:0]   crc;
    logic         fb;
    w        = '0;
    w[2]     = cfg.copy;
    w[5:3]   = cfg.pre ? 3'b001 : 3'b000;
    w[15:8]  = cfg.cat;
    w[23:20] = cfg.chen ? 4'(ch + 1) : 4'd0;
    w[27:24] = cfg.fs;
    w[35:32] = cfg.wl;
    w[39:36] = ~cfg.fs;
    crc = 8'hFF;
    for (int i = 0; i < 184; i++) begin
      fb  = crc[7] ^ w[i];
      crc = {crc[6:0], 1'b0};
      if (fb) crc = crc ^ 8'h1D;
    end
`ifdef SPDIF_CS_CRCC_EN
    w[191:184] = crc;
`endif
    return w;
  endfunction

  task automatic model_latch();
    cfg_t cfg;
    cfg = '{categoryCode, samplingFreq, wordLength, copyPermit, preEmphasis, channelNumEn};
    for (int unsigned c = 0; c < NC; c++) m_word[c] = build_word(cfg, c);
    m_cl = 1'b1;
  endtask

  task automatic model_emit();
    m_oidx = m_idx;
    m_bs   = (m_idx == 8'd0);
    for (int unsigned c = 0; c < NC; c++) m_bits[c] = m_word[c][m_idx];
  endtask

  task automatic model_step(input logic s);
    m_cl = 1'b0;
    if (!nReset) begin
      m_run = 1'b0; m_idx = '0; m_bits = '0; m_bs = 1'b0; m_oidx = '0;
      for (int unsigned c = 0; c < NC; c++) m_word[c] = '0;
    end else if (s) begin
      if (!m_run) begin
        if (enable) begin
          model_latch(); m_run = 1'b1; m_idx = '0; model_emit();
        end
      end else if (m_idx == 8'd191) begin
        if (enable) begin
          model_latch(); m_idx = '0; model_emit();
        end else begin
          m_run = 1'b0; m_idx = '0; m_bits = '0; m_bs = 1'b0; m_oidx = '0;
        end
      end else begin
        m_idx = m_idx + 8'd1;
        model_emit();
      end
    end
  endtask

  task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step(input logic s);
    exp_t e;
    logic cap_en;
    frameStrobe = s;
    model_step(s);
    e.bits = m_bits; e.bs = m_bs; e.idx = m_oidx; e.cl = m_cl;
    q.push_back(e);
    cap_en = s && nReset && m_run;
    @(posedge clk);
    #1;
    e = q.pop_front();
    check("csBits",        192'(csBits),        192'(e.bits));
    check("blockStart",    192'(blockStart),    192'(e.bs));
    check("frameIndex",    192'(frameIndex),    192'(e.idx));
    check("configLatched", 192'(configLatched), 192'(e.cl));
    if (cap_en)
      for (int unsigned c = 0; c < NC; c++) cap[c][e.idx] = csBits[c];
  endtask

  task automatic strobes(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      step(1'b1);
      for (int g = 0; g < gap; g++) step(1'b0);
    end
  endtask

  initial begin
    nReset = 1'b0; enable = 1'b0; frameStrobe = 1'b0;
    categoryCode = '0; samplingFreq = '0; wordLength = '0;
    copyPermit = 1'b0; preEmphasis = 1'b0; channelNumEn = 1'b0;
    m_run = 1'b0; m_idx = '0; m_bits = '0; m_bs = 1'b0; m_oidx = '0; m_cl = 1'b0;
    for (int unsigned c = 0; c < NC; c++) begin m_word[c] = '0; cap[c] = '0; end

    // reset with strobes toggling
    enable = 1'b1;
    step(1'b1); step(1'b0); step(1'b1);
    check("reset_csBits", 192'(csBits), 192'(0));
    enable = 1'b0;
    nReset = 1'b1;
    step(1'b0);

    // first block, back-to-back strobes
    categoryCode = 8'h99; samplingFreq = 4'd2; wordLength = 4'd2; channelNumEn = 1'b1;
    enable = 1'b1;
    strobes(192, 0);
    check("ch0_word", {8'h0, cap[0][183:0]}, 192'(40'hD202109900));
    check("ch1_word", {8'h0, cap[1][183:0]}, 192'(40'hD202209900));

    // mid-block config change only affects the next block
    strobes(101, 0);
    categoryCode = 8'h00;
    strobes(91, 0);
    check("blk_cat_old", 192'(cap[0][15:8]), 192'(8'h99));
    strobes(192, 1);
    check("blk_cat_new", 192'(cap[0][15:8]), 192'(8'h00));

    // enable dropped mid-block: block completes, then idles
    strobes(51, 0);
    enable = 1'b0;
    strobes(141, 0);
    strobes(3, 1);
    check("idle_frameIndex", 192'(frameIndex), 192'(0));
    enable = 1'b1;
    step(1'b1);
    check("reraise_bs", 192'(blockStart), 192'(1));
    strobes(191, 0);

    // reset mid-block aborts; next strobe starts a fresh block
    strobes(20, 0);
    nReset = 1'b0;
    step(1'b1);
    nReset = 1'b1;
    step(1'b0);
    step(1'b1);
    check("post_reset_bs", 192'(blockStart), 192'(1));
    strobes(191, 0);

    // strobe spacing must not change the stream
    categoryCode = 8'h45; samplingFreq = 4'd3; wordLength = 4'hB;
    copyPermit = 1'b1; preEmphasis = 1'b1;
    strobes(192, 0);
    capA = cap[0];
    strobes(192, 63);
    capB = cap[0];
    check("spacing_equal", capB, capA);
    check("copy_pre", 192'(capA[5:2]), 192'(4'b0011));
    check("spacing_model", capA, m_word[0]);

`ifdef SPDIF_CS_CRCC_EN
    for (int r = 0; r < 3; r++) begin
      categoryCode = 8'($urandom);
      samplingFreq = 4'($urandom);
      wordLength   = 4'($urandom);
      copyPermit   = 1'($urandom);
      preEmphasis  = 1'($urandom);
      channelNumEn = 1'($urandom);
      strobes(192, 0);
      for (int unsigned c = 0; c < NC; c++)
        check("crc", 192'(cap[c][191:184]), 192'(m_word[c][191:184]));
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
